// File: rtl/ball_movement.sv
// Single-LED "pong" between two buttons: the ball walks across a 16-bit LED
// bar, each player returns it from their end, a miss shows a point banner.
module ball_movement #(
   parameter int STEP_DIV    = 2,
   parameter int POINT_TICKS = 4
) (
   input  logic        clk,
   input  logic        reset_clk,
   input  logic        but_1,
   input  logic        but_2,
   output logic [15:0] led
);

   localparam int CNT_W = $clog2(STEP_DIV);
   localparam int PT_W  = $clog2(POINT_TICKS + 1);

   typedef enum logic [1:0] {SERVE, RALLY, POINT} state_t;

   // Player 1 owns position 15, player 2 owns position 0.
   localparam logic P1       = 1'b0;
   localparam logic P2       = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   state_t           state, state_next;
   logic             server, server_next;
   logic             dir, dir_next;
   logic             winner, winner_next;
   logic [3:0]       pos, pos_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [PT_W-1:0]  pt_cnt, pt_cnt_next;
   logic [15:0]      led_next;

   logic tick;
   logic at_end;
   logic rcv_but;
   logic serve_but;

   assign tick      = (state != SERVE) && (cnt == CNT_W'(STEP_DIV - 1));
   assign at_end    = (dir == DIR_UP) ? (pos == 4'd15) : (pos == 4'd0);
   assign rcv_but   = (dir == DIR_UP) ? but_1 : but_2;
   assign serve_but = (server == P1) ? but_1 : but_2;

   always_ff @(posedge clk) begin
      if (reset_clk) begin
         state  <= SERVE;
         server <= P1;
         dir    <= DIR_DOWN;
         winner <= P1;
         pos    <= 4'd15;
         cnt    <= '0;
         pt_cnt <= '0;
         led    <= 16'h8000;
      end else begin
         state  <= state_next;
         server <= server_next;
         dir    <= dir_next;
         winner <= winner_next;
         pos    <= pos_next;
         cnt    <= cnt_next;
         pt_cnt <= pt_cnt_next;
         led    <= led_next;
      end
   end

   // A return is accepted any time the ball sits at the receiver's end up to
   // and including the tick; the same tick then carries the ball back out.
   always_comb begin
      state_next  = state;
      server_next = server;
      dir_next    = dir;
      winner_next = winner;
      pos_next    = pos;
      pt_cnt_next = pt_cnt;

      case (state)
         SERVE: begin
            pos_next = (server == P1) ? 4'd15 : 4'd0;
            if (serve_but) begin
               state_next = RALLY;
               dir_next   = (server == P1) ? DIR_DOWN : DIR_UP;
            end
         end
         RALLY: begin
            if (at_end) begin
               if (rcv_but) begin
                  dir_next = ~dir;
                  if (tick)
                     pos_next = (dir == DIR_UP) ? pos - 4'd1 : pos + 4'd1;
               end else if (tick) begin
                  state_next  = POINT;
                  winner_next = (dir == DIR_UP) ? P2 : P1;
                  server_next = (dir == DIR_UP) ? P1 : P2;
                  pt_cnt_next = '0;
               end
            end else if (tick) begin
               pos_next = (dir == DIR_UP) ? pos + 4'd1 : pos - 4'd1;
            end
         end
         POINT: begin
            if (tick) begin
               if (pt_cnt == PT_W'(POINT_TICKS - 1)) begin
                  state_next = SERVE;
                  pos_next   = (server == P1) ? 4'd15 : 4'd0;
               end else begin
                  pt_cnt_next = pt_cnt + PT_W'(1);
               end
            end
         end
         default: begin
            state_next = SERVE;
         end
      endcase

      if (state_next != state || state == SERVE || tick)
         cnt_next = '0;
      else
         cnt_next = cnt + CNT_W'(1);
   end

   // The display is registered alongside the state, so it is decoded from
   // the values the state registers are about to take.
   always_comb begin
      led_next = 16'b1 << pos_next;
      if (state_next == POINT)
         led_next = (winner_next == P1) ? 16'hFF00 : 16'h00FF;
   end

endmodule

// File: tb/tb_ball_movement.sv
// Scoreboard bench for ball_movement: stimulus pushes the expected display
// after each edge, a negedge monitor pops and compares.
module tb_ball_movement;

   logic        clk;
   logic        reset_clk;
   logic        but_1;
   logic        but_2;
   logic [15:0] led;

   typedef struct {
      logic [15:0] exp;
      string       tag;
   } exp_t;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;

   ball_movement #(.STEP_DIV(2), .POINT_TICKS(4)) dut (
      .clk      (clk),
      .reset_clk(reset_clk),
      .but_1    (but_1),
      .but_2    (but_2),
      .led      (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the negedge; the expected display for the following
   // posedge is queued just after that edge.
   task automatic applyStimulus(input logic b1, input logic b2, input logic rst,
                                input logic [15:0] exp, input string tag);
      exp_t e;
      @(negedge clk);
      but_1     = b1;
      but_2     = b2;
      reset_clk = rst;
      @(posedge clk);
      #1;
      e.exp = exp;
      e.tag = tag;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      compared++;
      if (led !== e.exp) begin
         mismatched++;
         $display("[TB] FAIL %s: led=%h expected=%h", e.tag, led, e.exp);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0)
         checkOutput(expQ.pop_front());
   end

   initial begin
      but_1     = 1'b0;
      but_2     = 1'b0;
      reset_clk = 1'b0;

      // Reset, then idle: ball stays at player 1's end.
      applyStimulus(0, 0, 1, 16'h8000, "reset");
      for (int i = 0; i < 100; i++)
         applyStimulus(0, 0, 0, 16'h8000, "idle_serve");
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 1, 0, 16'h8000, "p2_ignored_in_p1_serve");

      // P1 serves (button held 2 cycles); ball steps every 2 cycles to bit 0.
      for (int e = 1; e <= 31; e++)
         applyStimulus(e <= 2, 0, 0, 16'h8000 >> ((e - 1) / 2), "rally_down");

      // P2 returns with a long hold; ball travels back to bit 15.
      for (int j = 1; j <= 30; j++)
         applyStimulus(0, 1, 0, 16'h0001 << (j / 2), "return_up");

      // P1 misses: P2 wins, banner for 8 cycles, both buttons ignored.
      applyStimulus(0, 1, 0, 16'h8000, "at_p1_end");
      applyStimulus(0, 1, 0, 16'h00FF, "p2_point_first");
      for (int j = 0; j < 7; j++)
         applyStimulus(1, 1, 0, 16'h00FF, "p2_point_hold");
      applyStimulus(1, 1, 0, 16'h8000, "p1_serve_after_point");
      for (int j = 0; j < 4; j++)
         applyStimulus(0, 1, 0, 16'h8000, "p2_ignored_p1_serve");

      // P1 serves again; P2 misses at bit 0, P1 wins.
      for (int e = 1; e <= 31; e++)
         applyStimulus(e == 1, 0, 0, 16'h8000 >> ((e - 1) / 2), "rally_down2");
      applyStimulus(0, 0, 0, 16'h0001, "at_p2_end");
      for (int j = 0; j < 8; j++)
         applyStimulus(1, 0, 0, 16'hFF00, "p1_point");
      applyStimulus(1, 0, 0, 16'h0001, "p2_serve_after_point");
      for (int j = 0; j < 3; j++)
         applyStimulus(1, 0, 0, 16'h0001, "p1_ignored_p2_serve");

      // P2 serves toward bit 15.
      for (int e = 1; e <= 31; e++)
         applyStimulus(0, e == 1, 0, 16'h0001 << ((e - 1) / 2), "rally_up");

      // P1 hits exactly on the tick: ball leaves in the same cycle.
      applyStimulus(0, 0, 0, 16'h8000, "wait_tick_p1");
      applyStimulus(1, 0, 0, 16'h4000, "tick_hit_p1");
      for (int j = 1; j <= 13; j++)
         applyStimulus(0, 0, 0, 16'h0001 << (14 - j / 2), "rally_down3");

      // Reset mid-rally with the ball at bit 8.
      applyStimulus(0, 0, 1, 16'h8000, "mid_rally_reset");
      for (int j = 0; j < 3; j++)
         applyStimulus(0, 0, 0, 16'h8000, "after_reset_idle");

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 4 && expQ.size() > 0; i++)
         @(negedge clk);
      #1;
      if (expQ.size() > 0) begin
         mismatched++;
         $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ball_movement.md
BALL_MOVEMENT -- requirements
Module: ball_movement

Interface
REQ-001 Parameter STEP_DIV, default 2: clock cycles per ball step (tick period); must be >= 2; hardware builds override it with a large value.
REQ-002 Parameter POINT_TICKS, default 4: number of ticks the point display is held.
REQ-003 clk  input  1  single system clock; all logic is rising-edge clk.
REQ-004 reset_clk  input  1  reset, synchronous and active-high.
REQ-005 but_1  input  1  player 1 button, level-sensitive, synchronous to clk; player 1 owns the led[15] end.
REQ-006 but_2  input  1  player 2 button, level-sensitive, synchronous to clk; player 2 owns the led[0] end.
REQ-007 led  output  16  registered ball/point display.

Function
REQ-008 States: SERVE, RALLY, POINT; internal registers: server (P1/P2), direction (toward led[0] / toward led[15]), ball position 0..15, tick counter.
REQ-009 Tick: the counter is cleared to 0 on entry to any state; in RALLY and POINT it counts 0..STEP_DIV-1; a tick is the cycle in which counter == STEP_DIV-1, after which the counter wraps to 0.
REQ-010 In SERVE and RALLY, led is one-hot with bit[position] = 1; all other bits 0.
REQ-011 In SERVE, the ball sits at the server's end (P1: position 15; P2: position 0).
REQ-012 In SERVE, the non-server's button is ignored.
REQ-013 In SERVE, the server's button high on any cycle moves the state to RALLY on the next edge, with direction away from the server.
REQ-014 In RALLY, on each tick the ball moves one position in the current direction (toward led[0] = position-1; toward led[15] = position+1), unless REQ-016 applies.
REQ-015 Receiver is the player owning the end the ball is moving toward.
REQ-016 Hit and miss, while the ball is at the receiver's end:
- Hit: the receiver's button high on any cycle after arrival, up to and including the next tick, flips direction.
- On a hit in a non-tick cycle, the ball stays put and leaves on the following tick.
- On a hit in the tick cycle itself, the direction flips and the ball moves one position away in that same cycle.
- Miss: if the next tick occurs with no hit, the state becomes POINT and the receiver loses the point.
REQ-017 Button presses while the ball is not at the presser's end are ignored without penalty; a held button is not an error.
REQ-018 The sender's button is ignored in RALLY.
REQ-019 POINT display:
- Player 1 won: led = 16'hFF00.
- Player 2 won: led = 16'h00FF.
- Both buttons are ignored.
REQ-020 After POINT_TICKS ticks in POINT, the state becomes SERVE with server = the player who lost the point and the ball at that player's end.
REQ-021 Position arithmetic is 4-bit and shall never wrap: moves only occur away from an end or toward the receiver's end, never past bit 0 or bit 15.

Reset
REQ-022 reset_clk high at a clock edge sets:
- state = SERVE, server = P1, position = 15, counter = 0;
- led = 16'h8000 from that edge onward.
REQ-023 Reset overrides all other activity in any state, including mid-rally and during POINT.
REQ-024 There is no internal power-up behaviour beyond the reset state; outputs are undefined until the first reset edge.

Verification (STEP_DIV=2, POINT_TICKS=4)
REQ-025 Reset for 1 cycle -> led = 16'h8000; no movement with both buttons low for 100 cycles.
REQ-026 but_1 high for 2 cycles -> led steps 8000, 4000, ... one bit per 2 cycles, reaching 16'h0001 about 30 cycles after the serve.
REQ-027 Ball at 16'h0001 and but_2 held high (press within 2 cycles, held long) -> led returns 0002, 0004, ... to 16'h8000; the held but_2 causes no further effect.
REQ-028 Ball reaches 16'h8000 and but_1 stays low -> led = 16'h00FF for 8 cycles, then 16'h8000 with P1 serving; only but_1 restarts play.
REQ-029 Ball at 16'h0001 and but_2 low through the next tick -> led = 16'hFF00 for 8 cycles, then 16'h0001; but_1 is ignored and but_2 serves toward led[15].
REQ-030 reset_clk asserted mid-rally at led = 16'h0100 -> led = 16'h8000 on the next edge, state SERVE.
